// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto a 2-bit-per-symbol stream produced by a 3-bit LFSR
// (next = {s2^s0, s2, s1}, symbol = {s1, s0}), then counts matching and
// mismatching symbols and drops lock after LOSS_THRESH consecutive mismatches.
//
// state  | meaning
// -------+-------------------------------------------------------------
// HUNT   | waiting for the first symbol of a seed pair
// SEED   | one symbol captured, testing the next one for consistency
// LOCKED | predictor running, every valid symbol compared against it
module lfsr_checker #(
    parameter int LOSS_THRESH = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [1:0]       symbol,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] good_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SEED   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [2:0]       LOSS_TC = 3'(LOSS_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [2:0] lfsr_next(input logic [2:0] s);
        return {s[2] ^ s[0], s[2], s[1]};
    endfunction

    state_t     state;
    logic [2:0] pred;
    logic [1:0] cap;
    logic [2:0] run;

    logic [2:0] seed_state;
    logic       seed_ok;
    logic [2:0] pred_next;
    logic       sym_match;
    logic [2:0] run_inc;
    logic       inc_good;
    logic       inc_err;

    // Seed consistency, next prediction and counter-increment requests.
    always_comb begin
        seed_state = {symbol[1], cap};
        seed_ok    = (symbol[0] == cap[1]) && (seed_state != 3'b000);
        pred_next  = lfsr_next(pred);
        sym_match  = (pred_next[1:0] == symbol);
        run_inc    = run + 3'd1;
        inc_good   = valid && (state == LOCKED) && sym_match;
        inc_err    = valid && (state == LOCKED) && !sym_match;
    end

    // Lock FSM, predictor, mismatch run length and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HUNT;
            pred   <= 3'b111;
            cap    <= 2'b00;
            run    <= 3'd0;
            locked <= 1'b0;
            error  <= 1'b0;
        end else begin
            error <= 1'b0;
            if (valid) begin
                case (state)
                    HUNT: begin
                        cap   <= symbol;
                        state <= SEED;
                    end
                    SEED: begin
                        if (seed_ok) begin
                            // Low bits of next(seed_state) equal the symbol just seen.
                            pred   <= lfsr_next(seed_state);
                            run    <= 3'd0;
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            cap <= symbol;
                        end
                    end
                    LOCKED: begin
                        // The predictor steps on every symbol so a single corrupted
                        // symbol does not knock later comparisons out of phase.
                        pred <= pred_next;
                        if (sym_match) begin
                            run <= 3'd0;
                        end else begin
                            error <= 1'b1;
                            if (run_inc == LOSS_TC) begin
                                run    <= 3'd0;
                                state  <= HUNT;
                                locked <= 1'b0;
                            end else begin
                                run <= run_inc;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating match/mismatch counters; a clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (reset || clear_cnt) begin
            err_count  <= '0;
            good_count <= '0;
        end else begin
            if (inc_err && (err_count != CNT_MAX)) begin
                err_count <= err_count + 1'b1;
            end
            if (inc_good && (good_count != CNT_MAX)) begin
                good_count <= good_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter: LOSS_THRESH, default 3, consecutive mismatches in LOCKED that force loss of lock (legal 1..7).
REQ-002 Parameter: CNT_W, default 8, width of err_count and good_count.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 valid  input  1  symbol strobe; one symbol consumed per cycle with valid=1.
REQ-006 symbol  input  2  received symbol; generator convention: symbol = {state[1], state[0]} of a 3-bit LFSR, next state = {s2^s0, s2, s1}.
REQ-007 clear_cnt  input  1  synchronous clear of both counters.
REQ-008 locked  output  1  high while in LOCKED.
REQ-009 error  output  1  one-cycle pulse per mismatching symbol in LOCKED.
REQ-010 err_count  output  CNT_W  saturating count of mismatches.
REQ-011 good_count  output  CNT_W  saturating count of matching symbols in LOCKED.

Function
REQ-012 The FSM SHALL have states HUNT, SEED and LOCKED; valid=0 SHALL hold all state, counters and predictor.
REQ-013 HUNT + valid: capture symbol as {c1,c0}; go to SEED.
REQ-014 SEED + valid: consistency holds iff symbol[0]==c1 and {symbol[1],c1,c0}!=3'b000.
REQ-015 SEED, consistent: load predictor with next({symbol[1],c1,c0}) (low bits equal symbol); go to LOCKED; no counter change.
REQ-016 SEED, inconsistent: recapture symbol as {c1,c0}; stay in SEED; no counter change, no error pulse.
REQ-017 LOCKED + valid: expected = next(predictor)[1:0]; predictor SHALL advance to next(predictor) regardless of match.
REQ-018 Match: good_count +1 (saturate), mismatch run counter cleared.
REQ-019 Mismatch: error=1 in the following cycle, err_count +1 (saturate at all ones), mismatch run counter +1.
REQ-020 Mismatch run counter reaching LOSS_THRESH: go to HUNT at that edge, locked falls the same edge, run counter cleared; the error pulse for that symbol is still issued.
REQ-021 Outputs SHALL be registered; error/locked latency = 1 cycle after the sampled valid symbol.
REQ-022 clear_cnt zeroes err_count and good_count; when clear_cnt and an increment coincide, clear wins (result 0); clear_cnt does not affect FSM, predictor or error.
REQ-023 Counters at all ones SHALL hold, never wrap.
REQ-024 Predictor SHALL never hold 3'b000 (guaranteed by REQ-014 and LFSR closure).

Reset
REQ-025 reset=1 at any edge, including mid-stream in any state: FSM=HUNT, predictor=3'b111, captured symbol=2'b00, run counter=0, locked=0, error=0, err_count=0, good_count=0.
REQ-026 reset SHALL take priority over valid and clear_cnt.
REQ-027 First symbol after reset release starts HUNT capture per REQ-013.

Verification
REQ-028 Clean lock: after reset, valid every cycle with period-7 stream 11,11,01,10,01,00,10,... -> locked rises 1 cycle after 2nd symbol; good_count=12 after 14 symbols; error never asserted.
REQ-029 Single bit error: locked stream, one symbol corrupted (01 sent as 11) -> error pulse exactly 1 cycle, err_count=1, locked stays 1, following correct symbols match (predictor advanced).
REQ-030 Loss of lock: locked stream replaced by constant 00 -> three error pulses, locked falls with the third, FSM in HUNT; restoring valid stream relocks after 2 symbols.
REQ-031 Inconsistent seed: symbols 11 then 10 (bit0≠c1) -> stays SEED, locked=0; next symbol 01 -> locked=1.
REQ-032 Saturation/clear: force 300 mismatches with CNT_W=8 (LOSS_THRESH=7, repeated relock) -> err_count holds 255; clear_cnt asserted in a cycle with a pending mismatch -> err_count=0.
REQ-033 Reset mid-stream while LOCKED with err_count=5 -> next cycle locked=0, counters 0, valid gaps (valid=0) inserted anywhere change nothing.
